imm_gen_seq: RTL and testbench



---
 rtl/imm_gen_pkg.sv | 16 +
 rtl/imm_extend.sv | 24 ++
 rtl/imm_gen_seq.sv | 98 +++++++++
 tb/tb_imm_gen_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared encodings for the registered immediate generator.
package imm_gen_pkg;

  // Extension mode encodings carried on the 2-bit Mode input.
  localparam logic [1:0] MODE_SE  = 2'd0;
  localparam logic [1:0] MODE_ZE  = 2'd1;
  localparam logic [1:0] MODE_UP  = 2'd2;
  localparam logic [1:0] MODE_PFX = 2'd3;

  // IDLE: no prefix held.  HELD: a prefix field waits for its partner.
  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

endpackage

// File: rtl/imm_extend.sv
// Combinational extension of the immediate field for SE, ZE and UP modes.
module imm_extend
  import imm_gen_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8
) (
  input  logic [IMM_W-1:0]  f,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] ext
);

  // Pick the extension; PFX yields zero because the top never uses it.
  always_comb begin
    ext = '0;
    unique case (mode)
      MODE_SE: ext = {{(DATA_W-IMM_W){f[IMM_W-1]}}, f};
      MODE_ZE: ext = {{(DATA_W-IMM_W){1'b0}}, f};
      MODE_UP: ext = {f, {(DATA_W-IMM_W){1'b0}}};
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen_seq.sv
// Registered immediate generator with prefix support for full-width constants.
//
// Handshake: there is no back-pressure. An instruction is accepted on every
// rising edge where InValid is 1 and Flush is 0. OutValid is 1 for exactly the
// cycle after an accepted non-prefix instruction, and Output holds its last
// value otherwise. Flush wins over a same-cycle instruction and drops it.
module imm_gen_seq
  import imm_gen_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Input,
  input  logic [1:0]        Mode,
  input  logic              InValid,
  input  logic              Flush,
  output logic [DATA_W-1:0] Output,
  output logic              OutValid,
  output logic              PrefixPending,
  output state_t            dbg_state
);

  // The concatenation and UP placement only make sense in this range.
  if (!(IMM_W < DATA_W && DATA_W <= 2 * IMM_W)) begin : g_param_check
    $error("imm_gen_seq: need IMM_W < DATA_W <= 2*IMM_W");
  end

  state_t                   state, next_state;
  logic [IMM_W-1:0]         held, next_held;
  logic [DATA_W-1:0]        next_out;
  logic                     next_valid;
  logic [IMM_W-1:0]         f;
  logic [DATA_W-1:0]        ext;
  logic [2*IMM_W-1:0]       cat;
  logic                     unused_input_hi;

  assign f               = Input[IMM_W-1:0];
  assign cat             = {held, f};
  assign unused_input_hi = ^Input[DATA_W-1:IMM_W];

  imm_extend #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_extend (
    .f    (f),
    .mode (Mode),
    .ext  (ext)
  );

  // Next-state, held prefix and output selection.
  always_comb begin
    next_state = state;
    next_held  = held;
    next_out   = Output;
    next_valid = 1'b0;
    if (Flush) begin
      next_state = IDLE;
      next_held  = '0;
    end else if (InValid) begin
      if (Mode == MODE_PFX) begin
        // A new prefix replaces any older one; prefixes never accumulate.
        next_state = HELD;
        next_held  = f;
      end else begin
        next_valid = 1'b1;
        if (state == HELD) begin
          // Raw concatenation; the mode extension is ignored here.
          next_out   = cat[DATA_W-1:0];
          next_state = IDLE;
          next_held  = '0;
        end else begin
          next_out = ext;
        end
      end
    end
  end

  // State, prefix and output registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      held     <= '0;
      Output   <= '0;
      OutValid <= 1'b0;
    end else begin
      state    <= next_state;
      held     <= next_held;
      Output   <= next_out;
      OutValid <= next_valid;
    end
  end

  assign PrefixPending = (state == HELD);
  assign dbg_state     = state;

endmodule

// File: tb/tb_imm_gen_seq.sv
// Directed self-checking bench for imm_gen_seq (DATA_W=16, IMM_W=8).
module tb_imm_gen_seq;
  import imm_gen_pkg::*;

  logic        CLK;
  logic        Reset;
  logic [15:0] Input;
  logic [1:0]  Mode;
  logic        InValid;
  logic        Flush;
  logic [15:0] Output;
  logic        OutValid;
  logic        PrefixPending;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  imm_gen_seq #(.DATA_W(16), .IMM_W(8)) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .Input         (Input),
    .Mode          (Mode),
    .InValid       (InValid),
    .Flush         (Flush),
    .Output        (Output),
    .OutValid      (OutValid),
    .PrefixPending (PrefixPending),
    .dbg_state     (dbg_state)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one cycle of stimulus and sample 1 time unit after the edge.
  task automatic step(input logic [1:0] m, input logic [15:0] d,
                      input logic v, input logic fl);
    Mode    = m;
    Input   = d;
    InValid = v;
    Flush   = fl;
    @(posedge CLK);
    #1;
    InValid = 1'b0;
    Flush   = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1; Input = '0; Mode = '0; InValid = 1'b0; Flush = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (Output !== 16'h0000 || OutValid !== 1'b0 || PrefixPending !== 1'b0) begin
      $display("FAIL reset_state: got out=%h v=%b p=%b expected 0000 0 0", Output, OutValid, PrefixPending);
      errors++;
    end
    Reset = 1'b0;
  endtask

  task automatic test_se;
    logic [15:0] sum;
    step(MODE_SE, 16'h0088, 1'b1, 1'b0);
    checks++;
    if (Output !== 16'hFF88 || OutValid !== 1'b1) begin
      $display("FAIL se_neg: got out=%h v=%b expected ff88 1", Output, OutValid);
      errors++;
    end
    sum = Output + 16'h0005;
    checks++;
    if (sum !== 16'hFF8D) begin
      $display("FAIL se_add: got %h expected ff8d", sum);
      errors++;
    end
    step(MODE_SE, 16'hAA7F, 1'b1, 1'b0);
    checks++;
    if (Output !== 16'h007F) begin
      $display("FAIL se_pos: got %h expected 007f", Output);
      errors++;
    end
    // Idle cycle: Output holds, OutValid drops.
    step(MODE_SE, 16'h00FF, 1'b0, 1'b0);
    checks++;
    if (Output !== 16'h007F || OutValid !== 1'b0) begin
      $display("FAIL idle_hold: got out=%h v=%b expected 007f 0", Output, OutValid);
      errors++;
    end
  endtask

  task automatic test_ze_up;
    step(MODE_ZE, 16'h0088, 1'b1, 1'b0);
    checks++;
    if (Output !== 16'h0088 || OutValid !== 1'b1) begin
      $display("FAIL ze: got out=%h v=%b expected 0088 1", Output, OutValid);
      errors++;
    end
    step(MODE_UP, 16'h0012, 1'b1, 1'b0);
    checks++;
    if (Output !== 16'h1200 || OutValid !== 1'b1) begin
      $display("FAIL up: got out=%h v=%b expected 1200 1", Output, OutValid);
      errors++;
    end
  endtask

  task automatic test_prefix_pair;
    step(MODE_PFX, 16'h00AB, 1'b1, 1'b0);
    checks++;
    if (Output !== 16'h1200 || OutValid !== 1'b0 || PrefixPending !== 1'b1 || dbg_state !== HELD) begin
      $display("FAIL pfx_held: got out=%h v=%b p=%b expected 1200 0 1", Output, OutValid, PrefixPending);
      errors++;
    end
    step(MODE_SE, 16'h00CD, 1'b1, 1'b0);
    checks++;
    if (Output !== 16'hABCD || OutValid !== 1'b1 || PrefixPending !== 1'b0) begin
      $display("FAIL pfx_pair: got out=%h v=%b p=%b expected abcd 1 0", Output, OutValid, PrefixPending);
      errors++;
    end
  endtask

  task automatic test_double_prefix;
    step(MODE_PFX, 16'h0011, 1'b1, 1'b0);
    step(MODE_PFX, 16'h0022, 1'b1, 1'b0);
    checks++;
    if (PrefixPending !== 1'b1 || OutValid !== 1'b0) begin
      $display("FAIL dbl_pending: got p=%b v=%b expected 1 0", PrefixPending, OutValid);
      errors++;
    end
    step(MODE_ZE, 16'h0033, 1'b1, 1'b0);
    checks++;
    if (Output !== 16'h2233 || OutValid !== 1'b1) begin
      $display("FAIL dbl_out: got out=%h v=%b expected 2233 1", Output, OutValid);
      errors++;
    end
  endtask

  task automatic test_held_idle;
    step(MODE_PFX, 16'h0055, 1'b1, 1'b0);
    step(MODE_SE, 16'h0099, 1'b0, 1'b0);
    checks++;
    if (PrefixPending !== 1'b1 || OutValid !== 1'b0 || Output !== 16'h2233) begin
      $display("FAIL held_idle: got out=%h v=%b p=%b expected 2233 0 1", Output, OutValid, PrefixPending);
      errors++;
    end
    step(MODE_UP, 16'h0066, 1'b1, 1'b0);
    checks++;
    if (Output !== 16'h5566) begin
      $display("FAIL held_cat: got %h expected 5566", Output);
      errors++;
    end
  endtask

  task automatic test_flush;
    step(MODE_PFX, 16'h00AB, 1'b1, 1'b0);
    step(MODE_SE, 16'h0001, 1'b1, 1'b1);
    checks++;
    if (OutValid !== 1'b0 || PrefixPending !== 1'b0 || Output !== 16'h5566) begin
      $display("FAIL flush_collide: got out=%h v=%b p=%b expected 5566 0 0", Output, OutValid, PrefixPending);
      errors++;
    end
    step(MODE_SE, 16'h0001, 1'b1, 1'b0);
    checks++;
    if (Output !== 16'h0001 || OutValid !== 1'b1) begin
      $display("FAIL flush_after: got out=%h v=%b expected 0001 1", Output, OutValid);
      errors++;
    end
    // Flush in IDLE only drops the instruction.
    step(MODE_ZE, 16'h00EE, 1'b1, 1'b1);
    checks++;
    if (Output !== 16'h0001 || OutValid !== 1'b0 || PrefixPending !== 1'b0) begin
      $display("FAIL flush_idle: got out=%h v=%b p=%b expected 0001 0 0", Output, OutValid, PrefixPending);
      errors++;
    end
  endtask

  task automatic test_reset_mid_prefix;
    step(MODE_PFX, 16'h00AB, 1'b1, 1'b0);
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (Output !== 16'h0000 || OutValid !== 1'b0 || PrefixPending !== 1'b0) begin
      $display("FAIL reset_mid: got out=%h v=%b p=%b expected 0000 0 0", Output, OutValid, PrefixPending);
      errors++;
    end
    #1 Reset = 1'b0;
    step(MODE_SE, 16'h00CD, 1'b1, 1'b0);
    checks++;
    if (Output !== 16'hFFCD || OutValid !== 1'b1) begin
      $display("FAIL reset_after: got out=%h v=%b expected ffcd 1", Output, OutValid);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_se();
    test_ze_up();
    test_prefix_pair();
    test_double_prefix();
    test_held_idle();
    test_flush();
    test_reset_mid_prefix();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
